error_decimator: RTL and testbench

Downstream stage of the LMS adaptive FIR: consumes the 32-bit registered error stream (e_out) of the adaptive filter, boxcar-averages it over a runtime-selectable power-of-two window, applies a fixed gain shift, and saturates to a 16-bit word with a one-cycle valid strobe. It feeds the slow-rate output path (DAC/readout) of the balanced-detection chain and keeps a saturation counter for monitoring.

---
 rtl/error_decimator.sv | 88 ++++++++
 tb/tb_error_decimator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/error_decimator.sv
// Boxcar decimator for the LMS error stream: averages 2^dec_sel samples,
// applies a fixed gain shift and saturates to an OW-bit output strobe.
module error_decimator #(
    parameter int W2         = 32,
    parameter int OW         = 16,
    parameter int MAXLOG2    = 10,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [W2-1:0] e_in,
    input  logic                 en,
    input  logic [3:0]           dec_sel,
    input  logic                 clear,
    output logic signed [OW-1:0] dout,
    output logic                 dout_valid,
    output logic                 sat_flag,
    output logic [15:0]          sat_count
);

    localparam int AW = W2 + MAXLOG2;
    localparam int EW = $clog2(MAXLOG2 + 1);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] q;
    logic [MAXLOG2-1:0]   cnt;
    logic [MAXLOG2-1:0]   cnt_last;
    logic [EW-1:0]        dec_act;
    logic [EW-1:0]        dec_clamp;
    logic [AW-OW:0]       q_hi;
    logic                 frame_end;
    logic                 q_fits;
    logic                 sat_hit;
    logic signed [OW-1:0] q_sat;

    always_comb begin
        dec_clamp = (int'(dec_sel) > MAXLOG2) ? EW'(MAXLOG2) : EW'(dec_sel);
        cnt_last  = MAXLOG2'((1 << dec_act) - 1);
        sum       = acc + {{MAXLOG2{e_in[W2-1]}}, e_in};
        frame_end = en && (cnt == cnt_last);
        q         = sum >>> (int'(dec_act) + GAIN_SHIFT);
        // q fits in OW bits when everything above the sign bit is a sign copy
        q_hi      = q[AW-1:OW-1];
        q_fits    = (&q_hi) || !(|q_hi);
        sat_hit   = frame_end && !q_fits;
        if (q_fits)
            q_sat = q[OW-1:0];
        else if (q[AW-1])
            q_sat = {1'b1, {(OW-1){1'b0}}};
        else
            q_sat = {1'b0, {(OW-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            dec_act    <= dec_clamp;
            dout       <= '0;
            dout_valid <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (frame_end) begin
                acc        <= '0;
                cnt        <= '0;
                dec_act    <= dec_clamp;
                dout       <= q_sat;
                dout_valid <= 1'b1;
                sat_flag   <= !q_fits;
            end else if (en) begin
                acc <= sum;
                cnt <= cnt + MAXLOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            sat_count <= '0;
        else if (clear)
            sat_count <= {15'd0, sat_hit};
        else if (sat_hit && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end

endmodule

// File: tb/tb_error_decimator.sv
// Table-driven bench for error_decimator with an output scoreboard.
module tb_error_decimator;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [31:0] e_in = '0;
    logic               en = 1'b0;
    logic [3:0]         dec_sel = 4'd2;
    logic               clear = 1'b0;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               sat_flag;
    logic [15:0]        sat_count;

    error_decimator dut (
        .clk(clk),
        .reset(reset),
        .e_in(e_in),
        .en(en),
        .dec_sel(dec_sel),
        .clear(clear),
        .dout(dout),
        .dout_valid(dout_valid),
        .sat_flag(sat_flag),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        clr;
        logic [3:0]  dsel;
        logic [31:0] e;
        logic        expv;
        logic [15:0] dout;
        logic        sat;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [15:0] dout;
        logic        sat;
        logic [15:0] cnt;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mcnt = '0;
    logic [15:0] hold_d = '0;
    logic        hold_s = 1'b0;

    task automatic add(input logic rst, input logic en_i, input logic clr,
                       input logic [3:0] dsel, input logic [31:0] e,
                       input logic expv, input logic [15:0] d,
                       input logic sat);
        vec_t v;
        if (rst)
            mcnt = '0;
        else if (clr)
            mcnt = (expv && sat) ? 16'd1 : 16'd0;
        else if (expv && sat && mcnt != 16'hFFFF)
            mcnt = mcnt + 16'd1;
        v.rst  = rst;
        v.en   = en_i;
        v.clr  = clr;
        v.dsel = dsel;
        v.e    = e;
        v.expv = expv;
        v.dout = d;
        v.sat  = sat;
        v.cnt  = mcnt;
        vecs.push_back(v);
    endtask

    always @(posedge clk) begin
        #1;
        if (dout_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe t=%0t dout=%h", $time, dout);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                if (dout !== x.dout || sat_flag !== x.sat ||
                    sat_count !== x.cnt) begin
                    errors++;
                    $display("FAIL strobe t=%0t dout=%h exp=%h sat=%b exp=%b cnt=%0d exp=%0d",
                             $time, dout, x.dout, sat_flag, x.sat, sat_count, x.cnt);
                end
            end
        end
    end

    task automatic step(input vec_t v);
        exp_t x;
        @(negedge clk);
        reset   = v.rst;
        en      = v.en;
        clear   = v.clr;
        dec_sel = v.dsel;
        e_in    = v.e;
        if (v.expv) begin
            x.dout = v.dout;
            x.sat  = v.sat;
            x.cnt  = v.cnt;
            sbq.push_back(x);
        end
        @(posedge clk);
        #2;
        if (v.expv) begin
            checks++;
            if (sbq.size() != 0) begin
                errors++;
                $display("FAIL missing_strobe t=%0t pending=%0d exp_dout=%h",
                         $time, sbq.size(), v.dout);
                sbq.delete();
            end
            hold_d = v.dout;
            hold_s = v.sat;
        end else begin
            if (v.rst) begin
                hold_d = '0;
                hold_s = 1'b0;
            end
            checks++;
            if (dout_valid !== 1'b0 || dout !== hold_d ||
                sat_flag !== hold_s || sat_count !== v.cnt) begin
                errors++;
                $display("FAIL idle t=%0t valid=%b dout=%h exp=%h sat=%b exp=%b cnt=%0d exp=%0d",
                         $time, dout_valid, dout, hold_d, sat_flag, hold_s,
                         sat_count, v.cnt);
            end
        end
    endtask

    initial begin
        // reset held with live input, then one idle cycle after release
        for (int i = 0; i < 5; i++) add(1, 1, 0, 2, 32'd12345, 0, 0, 0);
        add(0, 0, 0, 2, 32'd12345, 0, 0, 0);

        // constant average over N=4
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, 2, 32'd100, (i % 4) == 3, 16'd100, 0);

        // floor rounding
        add(1, 0, 0, 2, 0, 0, 0, 0);
        add(0, 1, 0, 2, 32'hFFFFFFFF, 0, 0, 0);
        add(0, 1, 0, 2, 32'hFFFFFFFF, 0, 0, 0);
        add(0, 1, 0, 2, 32'hFFFFFFFF, 0, 0, 0);
        add(0, 1, 0, 2, 32'd0, 1, 16'hFFFF, 0);
        add(0, 1, 0, 2, 32'd1, 0, 0, 0);
        add(0, 1, 0, 2, 32'd1, 0, 0, 0);
        add(0, 1, 0, 2, 32'd1, 0, 0, 0);
        add(0, 1, 0, 2, 32'd0, 1, 16'h0000, 0);

        // saturation, counter and clear
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 0, 32'h7FFFFFFF, 1, 16'h7FFF, 1);
        for (int i = 0; i < 2; i++)
            add(0, 1, 0, 0, 32'h80000000, 1, 16'h8000, 1);
        add(0, 1, 1, 0, 32'h80000000, 1, 16'h8000, 1);
        add(0, 1, 0, 0, 32'd5, 1, 16'd5, 0);
        add(0, 1, 1, 0, 32'd5, 1, 16'd5, 0);

        // gaps in en, then a mid-frame window change
        add(1, 0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add(0, (i % 2) == 0, 0, 3, 32'd8, i == 14, 16'd8, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 0, (i < 3) ? 4'd3 : 4'd1, 32'd8, i == 7, 16'd8, 0);
        add(0, 1, 0, 1, 32'd6, 0, 0, 0);
        add(0, 1, 0, 1, 32'd10, 1, 16'd8, 0);
        add(0, 1, 0, 1, 32'hFFFFFFFD, 0, 0, 0);
        add(0, 1, 0, 1, 32'hFFFFFFFC, 1, 16'hFFFC, 0);

        // exponent above the limit clamps to a 1024-sample window
        add(1, 0, 0, 15, 0, 0, 0, 0);
        for (int i = 0; i < 1024; i++)
            add(0, 1, 0, 15, 32'hFFFFFC18, i == 1023, 16'hFC18, 0);

        // reset mid-frame discards the partial sum
        add(1, 0, 0, 2, 0, 0, 0, 0);
        add(0, 1, 0, 2, 32'd1000, 0, 0, 0);
        add(0, 1, 0, 2, 32'd1000, 0, 0, 0);
        add(1, 0, 0, 2, 32'd1000, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 2, 32'd4, i == 3, 16'd4, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 2, 32'd4, 0, 0, 0);

        foreach (vecs[i]) step(vecs[i]);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected pending=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
